// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
//   Shared types and helpers for the load/store unit.
//   mem_size_e  : access size encoding used on the request port
//   lsu_err_e   : response error code
//   lsu_state_e : LSU control states
//   be_mask     : byte-enable pattern for a size at a given lane offset
//   is_misaligned : natural-alignment test for a size
// ----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'b00,
        SIZE_HALF   = 2'b01,
        SIZE_WORD   = 2'b10,
        SIZE_DOUBLE = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_e;

    // Enables for the widest (64-bit) bus; narrower buses truncate the result.
    function automatic logic [7:0] be_mask(mem_size_e size, logic [2:0] off);
        logic [7:0] base;
        case (size)
            SIZE_BYTE: base = 8'h01;
            SIZE_HALF: base = 8'h03;
            SIZE_WORD: base = 8'h0F;
            default:   base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic is_misaligned(mem_size_e size, logic [2:0] a);
        case (size)
            SIZE_HALF:   return a[0];
            SIZE_WORD:   return |a[1:0];
            SIZE_DOUBLE: return |a[2:0];
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// ----------------------------------------------------------------------------
// lsu_bus_master_if
//   Groups the core request/response handshake and the data-bus signals.
//   master : the LSU side (drives req_ready, rsp_*, bus_req/we/addr/be/wdata)
//   slave  : the environment (core + bus slave) driving req_* and bus_ready/rdata
// ----------------------------------------------------------------------------
interface lsu_bus_master_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    // core side
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic [1:0]        rsp_err;
    // bus side
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [XLEN/8-1:0] bus_be;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_ready;
    logic [XLEN-1:0]   bus_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// ----------------------------------------------------------------------------
// lsu_lane_align
//   Combinational load-data alignment: shifts the addressed byte lane down to
//   bit 0, truncates to the access size and sign- or zero-extends to XLEN.
//   rdata_i    : full-width bus read data
//   off_i      : byte offset of the access within the bus word
//   size_i     : access size
//   unsigned_i : 1 = zero-extend, 0 = sign-extend
//   data_o     : extended load result
// ----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]             rdata_i,
    input  logic [$clog2(XLEN/8)-1:0]   off_i,
    input  mem_size_e                   size_i,
    input  logic                        unsigned_i,
    output logic [XLEN-1:0]             data_o
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            sign;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        // NOTE: every signal written here gets a value before the case so no
        // path through the block can leave it unassigned (which would infer a latch).
        mask = '1;
        sign = shifted[XLEN-1];
        case (size_i)
            SIZE_BYTE: begin
                mask = XLEN'(64'hFF);
                sign = shifted[7];
            end
            SIZE_HALF: begin
                mask = XLEN'(64'hFFFF);
                sign = shifted[15];
            end
            SIZE_WORD: begin
                mask = XLEN'(64'hFFFF_FFFF);
                sign = shifted[31];
            end
            default: ;
        endcase
        data_o = (sign && !unsigned_i) ? (shifted | ~mask) : (shifted & mask);
    end

endmodule

// File: rtl/lsu_bus_master.sv
// ----------------------------------------------------------------------------
// lsu_bus_master
//   Load/store unit between the core datapath and the data bus. Accepts one
//   request in IDLE, checks size/alignment, runs a bus access with wait states
//   and a timeout, then returns a one-cycle response.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   lsu   : request/response handshake and bus signals (master modport)
//   XLEN 32|64, ADDR_W bus address width, TIMEOUT max ACCESS cycles (1..65535)
// ----------------------------------------------------------------------------
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    lsu_bus_master_if.master   lsu
);

    localparam int              NB       = XLEN / 8;
    localparam int              OFF_W    = $clog2(NB);
    localparam bit              HAS_DBL  = (XLEN == 64);
    localparam logic [15:0]     CNT_LAST = 16'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    mem_size_e         size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    lsu_err_e          err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;

    logic [OFF_W-1:0]  off;
    logic [XLEN-1:0]   load_data;
    mem_size_e         req_size;

    assign off      = addr_q[OFF_W-1:0];
    assign req_size = mem_size_e'(lsu.req_size);

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .rdata_i    (rdata_q),
        .off_i      (off),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (load_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the latched request and captured data are reset as well, so
            // nothing stale can reach the outputs after a reset aborts an access.
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (lsu.req_valid) begin
                    we_d    = lsu.req_we;
                    size_d  = req_size;
                    uns_d   = lsu.req_unsigned;
                    addr_d  = lsu.req_addr;
                    wdata_d = lsu.req_wdata;
                    // Checks use the live request fields: the latched copies
                    // are not valid until the next cycle.
                    if (!HAS_DBL && req_size == SIZE_DOUBLE) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = RESP;
                    end else if (is_misaligned(req_size, lsu.req_addr[2:0])) begin
                        err_d   = ERR_MISALIGN;
                        state_d = RESP;
                    end else begin
                        err_d   = ERR_OK;
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // bus_ready takes priority over an expiring counter.
                if (lsu.bus_ready) begin
                    rdata_d = lsu.bus_rdata;
                    err_d   = ERR_OK;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on registered state only, so they are stable for a whole cycle.
    always_comb begin
        lsu.req_ready = (state_q == IDLE);
        lsu.bus_req   = 1'b0;
        lsu.bus_we    = 1'b0;
        lsu.bus_addr  = '0;
        lsu.bus_be    = '0;
        lsu.bus_wdata = '0;
        lsu.rsp_valid = 1'b0;
        lsu.rsp_err   = ERR_OK;
        lsu.rsp_rdata = '0;

        if (state_q == ACCESS) begin
            lsu.bus_req   = 1'b1;
            lsu.bus_we    = we_q;
            lsu.bus_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            lsu.bus_be    = NB'(be_mask(size_q, 3'(off)));
            lsu.bus_wdata = wdata_q << {off, 3'b000};
        end

        if (state_q == RESP) begin
            lsu.rsp_valid = 1'b1;
            lsu.rsp_err   = err_q;
            if (!we_q && err_q == ERR_OK) begin
                lsu.rsp_rdata = load_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_master.sv
// ----------------------------------------------------------------------------
// tb_lsu_bus_master
//   Self-checking bench for lsu_bus_master. Runs a 32-bit instance (TIMEOUT=4)
//   and a 64-bit instance (TIMEOUT=7) through directed scenarios and random
//   transactions, predicting each response from the access rules with plain
//   arithmetic.
// ----------------------------------------------------------------------------
module tb_lsu_bus_master;
    import lsu_pkg::*;

    localparam int TO32 = 4;
    localparam int TO64 = 7;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    lsu_bus_master_if #(.XLEN(32), .ADDR_W(32)) if32 ();
    lsu_bus_master_if #(.XLEN(64), .ADDR_W(32)) if64 ();

    lsu_bus_master #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO32)) u32 (
        .clk   (clk),
        .reset (reset),
        .lsu   (if32)
    );

    lsu_bus_master #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO64)) u64 (
        .clk   (clk),
        .reset (reset),
        .lsu   (if64)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic        req_ready;
        logic        rsp_valid;
        logic [1:0]  rsp_err;
        logic [63:0] rsp_rdata;
        logic        bus_req;
        logic        bus_we;
        logic [31:0] bus_addr;
        logic [7:0]  bus_be;
        logic [63:0] bus_wdata;
    } obs_t;

    function automatic obs_t sample(input bit sel);
        obs_t o;
        if (sel) begin
            o.req_ready = if64.req_ready;
            o.rsp_valid = if64.rsp_valid;
            o.rsp_err   = if64.rsp_err;
            o.rsp_rdata = if64.rsp_rdata;
            o.bus_req   = if64.bus_req;
            o.bus_we    = if64.bus_we;
            o.bus_addr  = if64.bus_addr;
            o.bus_be    = if64.bus_be;
            o.bus_wdata = if64.bus_wdata;
        end else begin
            o.req_ready = if32.req_ready;
            o.rsp_valid = if32.rsp_valid;
            o.rsp_err   = if32.rsp_err;
            o.rsp_rdata = {32'h0, if32.rsp_rdata};
            o.bus_req   = if32.bus_req;
            o.bus_we    = if32.bus_we;
            o.bus_addr  = if32.bus_addr;
            o.bus_be    = {4'h0, if32.bus_be};
            o.bus_wdata = {32'h0, if32.bus_wdata};
        end
        return o;
    endfunction

    task automatic drive_req(input bit sel, input logic v, input logic we, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a, input logic [63:0] wd);
        if (sel) begin
            if64.req_valid    = v;
            if64.req_we       = we;
            if64.req_size     = sz;
            if64.req_unsigned = uns;
            if64.req_addr     = a;
            if64.req_wdata    = wd;
        end else begin
            if32.req_valid    = v;
            if32.req_we       = we;
            if32.req_size     = sz;
            if32.req_unsigned = uns;
            if32.req_addr     = a;
            if32.req_wdata    = wd[31:0];
        end
    endtask

    task automatic drive_bus(input bit sel, input logic rdy, input logic [63:0] rd);
        if (sel) begin
            if64.bus_ready = rdy;
            if64.bus_rdata = rd;
        end else begin
            if32.bus_ready = rdy;
            if32.bus_rdata = rd[31:0];
        end
    endtask

    // One complete request. Entered and left at #1 after a rising edge with the
    // selected unit idle. 'waits' is the number of ACCESS cycles with bus_ready
    // low before the slave answers.
    task automatic txn(input bit sel, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd_in,
                       input int waits, input string tag);
        int          nb;
        int          to;
        int          bytes;
        int          off;
        logic [63:0] xmask;
        logic [63:0] rd;
        logic [63:0] fmask;
        logic [63:0] v;
        logic [1:0]  exp_err;
        int          exp_lat;
        int          exp_bus;
        logic [63:0] exp_be;
        logic [63:0] exp_addr;
        logic [63:0] exp_wd;
        logic [63:0] exp_rd;
        obs_t        o;
        int          nbus;
        int          lat;
        bit          got;
        bit          stable;

        nb    = sel ? 8 : 4;
        to    = sel ? TO64 : TO32;
        xmask = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        bytes = 1 << sz;
        off   = int'(a % nb);
        rd    = rd_in & xmask;

        if (!sel && sz == 2'b11) begin
            exp_err = 2'b10; exp_lat = 1; exp_bus = 0;
        end else if ((a % bytes) != 0) begin
            exp_err = 2'b01; exp_lat = 1; exp_bus = 0;
        end else if (waits >= to) begin
            exp_err = 2'b11; exp_lat = to + 1; exp_bus = to;
        end else begin
            exp_err = 2'b00; exp_lat = waits + 2; exp_bus = waits + 1;
        end

        exp_be   = ((64'd1 << bytes) - 64'd1) << off;
        exp_addr = 64'(a & ~(32'(nb) - 32'd1));
        exp_wd   = (wd << (8 * off)) & xmask;
        exp_rd   = 64'h0;
        if (!we && exp_err == 2'b00) begin
            fmask = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * bytes)) - 64'd1);
            v     = (rd >> (8 * off)) & fmask;
            if (!uns && v[8 * bytes - 1]) v = v | ~fmask;
            exp_rd = v & xmask;
        end

        o = sample(sel);
        check({tag, ".req_ready"}, 64'(o.req_ready), 64'd1);
        drive_req(sel, 1'b1, we, sz, uns, a, wd);
        @(posedge clk); #1;
        // Scramble the request fields: the unit must work from its latched copy.
        drive_req(sel, 1'b0, ~we, 2'($urandom), ~uns, $urandom, {$urandom, $urandom});

        nbus   = 0;
        lat    = 0;
        got    = 1'b0;
        stable = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            o = sample(sel);
            if (o.bus_req) begin
                if (nbus == 0) begin
                    check({tag, ".bus_be"},    64'(o.bus_be), exp_be);
                    check({tag, ".bus_addr"},  64'(o.bus_addr), exp_addr);
                    check({tag, ".bus_we"},    64'(o.bus_we), 64'(we));
                    check({tag, ".bus_wdata"}, o.bus_wdata, exp_wd);
                end else if (64'(o.bus_be) != exp_be || 64'(o.bus_addr) != exp_addr ||
                             o.bus_we != we || o.bus_wdata != exp_wd) begin
                    stable = 1'b0;
                end
                if (nbus == waits) drive_bus(sel, 1'b1, rd);
                else               drive_bus(sel, 1'b0, {$urandom, $urandom});
                nbus++;
            end else begin
                // bus_ready toggles freely outside ACCESS and must be ignored.
                drive_bus(sel, 1'($urandom), {$urandom, $urandom});
            end
            if (o.rsp_valid) begin
                got = 1'b1;
                lat = k;
                check({tag, ".rsp_err"},   64'(o.rsp_err), 64'(exp_err));
                check({tag, ".rsp_rdata"}, o.rsp_rdata, exp_rd);
                break;
            end
            @(posedge clk); #1;
        end

        if (!got) begin
            check({tag, ".rsp_seen"}, 64'd0, 64'd1);
        end else begin
            check({tag, ".latency"},    64'(lat), 64'(exp_lat));
            check({tag, ".bus_cycles"}, 64'(nbus), 64'(exp_bus));
            check({tag, ".bus_stable"}, 64'(stable), 64'd1);
            @(posedge clk); #1;
            o = sample(sel);
            check({tag, ".rsp_one_cycle"}, 64'(o.rsp_valid), 64'd0);
            check({tag, ".ready_after"},   64'(o.req_ready), 64'd1);
        end
        drive_bus(sel, 1'b0, 64'h0);
    endtask

    // Absolute time limit in case a wait somewhere never returns.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        obs_t        o;
        bit          sel;
        logic [1:0]  sz;
        logic [31:0] a;

        drive_req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 64'h0);
        drive_req(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 64'h0);
        drive_bus(1'b0, 1'b0, 64'h0);
        drive_bus(1'b1, 1'b0, 64'h0);

        // Reset state, sampled while reset is still low.
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            o = sample(s[0]);
            check("reset.req_ready", 64'(o.req_ready), 64'd1);
            check("reset.bus_req",   64'(o.bus_req),   64'd0);
            check("reset.rsp_valid", 64'(o.rsp_valid), 64'd0);
            check("reset.outputs",   {o.rsp_rdata | o.bus_wdata} | 64'({o.bus_be, o.bus_addr, o.rsp_err, o.bus_we}), 64'd0);
        end
        reset = 1'b1;
        @(posedge clk); #1;

        // Signed byte load from the top lane, zero-wait.
        txn(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 64'h0, 64'h8000_0000, 0, "t1_lb");
        // Half store to the upper lanes with three wait states.
        txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 64'h0000_BEEF, 64'h1234_5678, 3, "t2_sh");
        // Misaligned word load: no bus cycle.
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 64'h0, 64'h0, 0, "t3_mis");
        // Timeout, then the slave answering on the last allowed cycle.
        txn(1'b0, 1'b0, 2'b10, 1'b1, 32'h0000_0010, 64'h0, 64'hCAFE_F00D, 20, "t4_to");
        txn(1'b0, 1'b0, 2'b10, 1'b1, 32'h0000_0010, 64'h0, 64'hCAFE_F00D, TO32 - 1, "t4_edge");
        // Double access: full width on 64-bit, illegal on 32-bit.
        txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0008, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0, "t5_ld64");
        txn(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0008, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0, "t5_ld32");
        txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0006, 64'h0, 64'h8001_2345_6789_ABCD, TO64 - 1, "t5_lhu64");

        // Reset during the second ACCESS cycle aborts the request silently.
        drive_req(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0040, 64'h0);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 64'h0);
        o = sample(1'b0);
        check("t6.bus_req_before", 64'(o.bus_req), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        o = sample(1'b0);
        check("t6.bus_req_after",   64'(o.bus_req),   64'd0);
        check("t6.req_ready_after", 64'(o.req_ready), 64'd1);
        check("t6.rsp_valid_after", 64'(o.rsp_valid), 64'd0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            o = sample(1'b0);
            check("t6.no_rsp", 64'(o.rsp_valid | o.bus_req), 64'd0);
        end
        txn(1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0042, 64'h0, 64'hFFFF_9ABC, 1, "t6_next");

        // Random traffic on both widths.
        for (int i = 0; i < 300; i++) begin
            sel = 1'($urandom);
            sz  = 2'($urandom);
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            txn(sel, 1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom},
                {$urandom, $urandom}, $urandom_range(0, 9), sel ? "rnd64" : "rnd32");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
